// File: rtl/fetch_stage_pkg.sv
// Shared constants for the instruction-fetch stage.
// Default widths and the 2-bit fetch FSM encodings.
package fetch_stage_pkg;

   localparam int PC_WIDTH_DEF = 32;
   localparam int IWIDTH_DEF   = 32;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_FETCH = 2'd1;
   localparam logic [1:0] S_HOLD  = 2'd2;
   localparam logic [1:0] S_DROP  = 2'd3;

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory read port: fetch is master,
// memory is slave (req/addr out, ack/data back).
interface fetch_stage_if
   import fetch_stage_pkg::*;
#(
   parameter int PC_WIDTH = PC_WIDTH_DEF,
   parameter int IWIDTH   = IWIDTH_DEF
);

   logic                req;
   logic [PC_WIDTH-1:0] addr;
   logic                ack;
   logic [IWIDTH-1:0]   data;

   modport master (
      output req,
      output addr,
      input  ack,
      input  data
   );

   modport slave (
      input  req,
      input  addr,
      output ack,
      output data
   );

endinterface

// File: rtl/fetch_skid.sv
// One-entry instr/pc buffer holding an acknowledged
// instruction while decode is stalled.
module fetch_skid
   import fetch_stage_pkg::*;
#(
   parameter int PC_WIDTH = PC_WIDTH_DEF,
   parameter int IWIDTH   = IWIDTH_DEF
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                ld_i,
   input  logic                clr_i,
   input  logic [IWIDTH-1:0]   instr_i,
   input  logic [PC_WIDTH-1:0] pc_i,
   output logic [IWIDTH-1:0]   instr_o,
   output logic [PC_WIDTH-1:0] pc_o,
   output logic                valid_o
);

   logic [IWIDTH-1:0]   instr_q;
   logic [PC_WIDTH-1:0] pc_q;
   logic                valid_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         instr_q <= '0;
         pc_q    <= '0;
         valid_q <= 1'b0;
      end else if (clr_i) begin
         valid_q <= 1'b0;
      end else if (ld_i) begin
         instr_q <= instr_i;
         pc_q    <= pc_i;
         valid_q <= 1'b1;
      end
   end

   assign instr_o = instr_q;
   assign pc_o    = pc_q;
   assign valid_o = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC, imem req/ack FSM, decode output
// with skid buffer, and execute-stage redirect handling.
module fetch_stage
   import fetch_stage_pkg::*;
#(
   parameter int                PC_WIDTH = PC_WIDTH_DEF,
   parameter int                IWIDTH   = IWIDTH_DEF,
   parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
   input  logic                fs_i_clk,
   input  logic                fs_i_rst,
   input  logic                fs_i_stall,
   input  logic                fs_i_change_pc,
   input  logic [PC_WIDTH-1:0] fs_i_alu_pc,
   fetch_stage_if.master       imem,
   output logic [IWIDTH-1:0]   fs_o_instr,
   output logic [PC_WIDTH-1:0] fs_o_pc,
   output logic                fs_o_ce
);

   localparam logic [PC_WIDTH-1:0] PC_INC = PC_WIDTH'(4);

   logic [1:0]          state_q, state_d;
   logic [PC_WIDTH-1:0] pc_q, pc_d;
   logic [PC_WIDTH-1:0] addr_q, addr_d;
   logic                req_q, req_d;
   logic [IWIDTH-1:0]   instr_q, instr_d;
   logic [PC_WIDTH-1:0] opc_q, opc_d;
   logic                ce_q, ce_d;

   logic                skid_ld, skid_clr;
   logic [IWIDTH-1:0]   skid_instr;
   logic [PC_WIDTH-1:0] skid_pc;
   logic                skid_vld;

   fetch_skid #(
      .PC_WIDTH (PC_WIDTH),
      .IWIDTH   (IWIDTH)
   ) u_skid (
      .clk_i   (fs_i_clk),
      .rst_i   (fs_i_rst),
      .ld_i    (skid_ld),
      .clr_i   (skid_clr),
      .instr_i (imem.data),
      .pc_i    (addr_q),
      .instr_o (skid_instr),
      .pc_o    (skid_pc),
      .valid_o (skid_vld)
   );

   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      addr_d   = addr_q;
      req_d    = req_q;
      instr_d  = instr_q;
      opc_d    = opc_q;
      ce_d     = ce_q;
      skid_ld  = 1'b0;
      skid_clr = 1'b0;

      if (fs_i_change_pc) begin
         pc_d     = fs_i_alu_pc;
         ce_d     = 1'b0;
         skid_clr = 1'b1;
      end

      unique case (state_q)
         S_IDLE: begin
            state_d = S_FETCH;
            req_d   = 1'b1;
            addr_d  = pc_d;
         end
         S_FETCH: begin
            if (fs_i_change_pc) begin
               // In-flight read keeps its address until acked
               if (imem.ack) addr_d = pc_d;
               else state_d = S_DROP;
            end else if (imem.ack) begin
               pc_d   = pc_q + PC_INC;
               addr_d = pc_d;
               if (!ce_q || !fs_i_stall) begin
                  instr_d = imem.data;
                  opc_d   = addr_q;
                  ce_d    = 1'b1;
               end else begin
                  skid_ld = 1'b1;
                  req_d   = 1'b0;
                  state_d = S_HOLD;
               end
            end else if (!fs_i_stall) begin
               ce_d = 1'b0;
            end
         end
         S_HOLD: begin
            if (fs_i_change_pc) begin
               state_d = S_FETCH;
               req_d   = 1'b1;
               addr_d  = pc_d;
            end else if (!fs_i_stall && skid_vld) begin
               instr_d  = skid_instr;
               opc_d    = skid_pc;
               ce_d     = 1'b1;
               skid_clr = 1'b1;
               state_d  = S_FETCH;
               req_d    = 1'b1;
               addr_d   = pc_q;
            end
         end
         S_DROP: begin
            if (imem.ack) begin
               state_d = S_FETCH;
               addr_d  = pc_d;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge fs_i_clk or posedge fs_i_rst) begin
      if (fs_i_rst) begin
         state_q <= S_IDLE;
         pc_q    <= RESET_PC;
         addr_q  <= RESET_PC;
         req_q   <= 1'b0;
         instr_q <= '0;
         opc_q   <= '0;
         ce_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         addr_q  <= addr_d;
         req_q   <= req_d;
         instr_q <= instr_d;
         opc_q   <= opc_d;
         ce_q    <= ce_d;
      end
   end

   assign imem.req   = req_q;
   assign imem.addr  = addr_q;
   assign fs_o_instr = instr_q;
   assign fs_o_pc    = opc_q;
   assign fs_o_ce    = ce_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed + randomized bench for fetch_stage with an
// instruction-stream reference model and bus rule checks.
module tb_fetch_stage;

   localparam int          PW  = 32;
   localparam int          IW  = 32;
   localparam logic [31:0] RPC = 32'h0;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        stall = 1'b0;
   logic        chg = 1'b0;
   logic [31:0] alu = '0;
   logic [31:0] instr;
   logic [31:0] opc;
   logic        ce;

   int          vectors = 0;
   int          errs = 0;
   bit          ack_on = 1'b0;
   logic [31:0] exp_pc = RPC;
   bit          drop_pend = 1'b0;

   fetch_stage_if #(.PC_WIDTH(PW), .IWIDTH(IW)) bus ();

   fetch_stage #(
      .PC_WIDTH (PW),
      .IWIDTH   (IW),
      .RESET_PC (RPC)
   ) dut (
      .fs_i_clk       (clk),
      .fs_i_rst       (rst),
      .fs_i_stall     (stall),
      .fs_i_change_pc (chg),
      .fs_i_alu_pc    (alu),
      .imem           (bus),
      .fs_o_instr     (instr),
      .fs_o_pc        (opc),
      .fs_o_ce        (ce)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mem(input logic [31:0] a);
      return {a[15:0], ~a[15:0]} ^ 32'h1357_9bdf;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic drive_mem();
      bus.ack  = bus.req & ack_on;
      bus.data = mem(bus.addr);
   endtask

   // One clock: rule checks derived from the bus/stream contract
   task automatic tick();
      logic        p_req, p_ack, p_chg, p_stall, p_ce;
      logic [31:0] p_addr, p_alu, p_pc, p_instr;
      bit          newo;
      p_req = bus.req;  p_ack = bus.ack;  p_addr = bus.addr;
      p_chg = chg;      p_alu = alu;      p_stall = stall;
      p_ce = ce;        p_pc = opc;       p_instr = instr;
      @(posedge clk);
      #1;
      if (p_chg) chk("redirect_ce", 32'(ce), 32'd0);
      if (p_req && !p_ack) begin
         chk("req_held", 32'(bus.req), 32'd1);
         chk("addr_held", bus.addr, p_addr);
      end
      if (p_req && p_ack && !p_chg && !drop_pend
          && (!p_ce || !p_stall)) begin
         chk("ack_to_pc", opc, p_addr);
         chk("ack_to_ce", 32'(ce), 32'd1);
      end
      if (p_ce && p_stall && !p_chg) begin
         chk("stall_ce", 32'(ce), 32'd1);
         chk("stall_pc", opc, p_pc);
         chk("stall_instr", instr, p_instr);
      end
      if (p_chg) exp_pc = p_alu;
      newo = ce && !(p_ce && p_stall);
      if (newo) begin
         chk("stream_pc", opc, exp_pc);
         chk("stream_instr", instr, mem(opc));
         exp_pc = exp_pc + 32'd4;
      end
      if (p_chg && p_req && !p_ack) drop_pend = 1'b1;
      else if (p_req && p_ack) drop_pend = 1'b0;
      drive_mem();
   endtask

   task automatic do_reset();
      #1;
      rst = 1'b1;
      #1;
      drive_mem();
      chk("rst_req", 32'(bus.req), 32'd0);
      chk("rst_addr", bus.addr, RPC);
      chk("rst_ce", 32'(ce), 32'd0);
      chk("rst_pc", opc, 32'd0);
      chk("rst_instr", instr, 32'd0);
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;
      exp_pc = RPC;
      drop_pend = 1'b0;
      drive_mem();
   endtask

   initial begin
      bus.ack  = 1'b0;
      bus.data = '0;
      ack_on   = 1'b1;
      do_reset();

      tick();
      chk("first_req", 32'(bus.req), 32'd1);
      chk("first_addr", bus.addr, 32'h0);
      tick();
      chk("seq_addr4", bus.addr, 32'h4);
      chk("seq_pc0", opc, 32'h0);
      tick();
      chk("seq_addr8", bus.addr, 32'h8);
      chk("seq_pc4", opc, 32'h4);

      stall = 1'b1;
      tick();
      chk("hold_req", 32'(bus.req), 32'd0);
      chk("hold_pc4", opc, 32'h4);
      tick();
      tick();
      chk("hold_pc4b", opc, 32'h4);
      chk("hold_ce", 32'(ce), 32'd1);
      stall = 1'b0;
      tick();
      chk("skid_pc8", opc, 32'h8);
      chk("skid_instr", instr, mem(32'h8));
      chk("resume_addr", bus.addr, 32'hc);
      tick();
      chk("seq_pc12", opc, 32'hc);
      chk("seq_addr16", bus.addr, 32'h10);

      ack_on = 1'b0;
      drive_mem();
      chg = 1'b1;
      alu = 32'h40;
      tick();
      chg = 1'b0;
      chk("drop_addr", bus.addr, 32'h10);
      chk("drop_ce", 32'(ce), 32'd0);
      tick();
      chk("drop_addr2", bus.addr, 32'h10);
      ack_on = 1'b1;
      drive_mem();
      tick();
      chk("drop_next", bus.addr, 32'h40);
      chk("drop_ce2", 32'(ce), 32'd0);
      tick();
      chk("tgt_pc40", opc, 32'h40);

      chg = 1'b1;
      alu = 32'h80;
      tick();
      chg = 1'b0;
      chk("ackredir_ce", 32'(ce), 32'd0);
      chk("ackredir_addr", bus.addr, 32'h80);
      tick();
      chk("ackredir_pc", opc, 32'h80);

      stall = 1'b1;
      tick();
      chk("hold2_req", 32'(bus.req), 32'd0);
      chg = 1'b1;
      alu = 32'h100;
      tick();
      chg = 1'b0;
      stall = 1'b0;
      chk("holdredir_ce", 32'(ce), 32'd0);
      chk("holdredir_addr", bus.addr, 32'h100);
      tick();
      chk("holdredir_pc", opc, 32'h100);

      ack_on = 1'b0;
      drive_mem();
      tick();
      chk("pend_addr", bus.addr, 32'h104);
      do_reset();
      ack_on = 1'b1;
      drive_mem();
      tick();
      chk("rerun_addr", bus.addr, RPC);
      chk("rerun_req", 32'(bus.req), 32'd1);

      for (int i = 0; i < 600; i++) begin
         stall  = ($urandom_range(0, 3) == 0);
         chg    = ($urandom_range(0, 11) == 0);
         alu    = $urandom_range(0, 4095) << 2;
         ack_on = ($urandom_range(0, 9) < 7);
         drive_mem();
         tick();
      end

      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, errs);
      $finish;
   end

endmodule
